// File: rtl/mmio_device_buffer.sv
// mmio_device_buffer: memory-mapped output port for the CPU data-memory bus.
//
// Stores to DATA_ADDR push words into a small FIFO. The FIFO drains to an
// external device over a valid/ready handshake. Loads from STATUS_ADDR return
// the occupancy and sticky error flags. Stores to STATUS_ADDR clear those flags.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   address         data-memory address
//   writeData       store data
//   memWrite        store strobe
//   memRead         load strobe
//   readData        load data (combinational, 0 when hit=0)
//   hit             address decodes to this device
//   devData         FIFO head word
//   devValid        FIFO non-empty
//   devReady        device accepts head word
//   irq             one-cycle pulse after the FIFO drains to empty
module mmio_device_buffer #(
  parameter logic [31:0] DATA_ADDR   = 32'hFFFF8004,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF8000,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CW          = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memWrite,
  input  logic        memRead,
  output logic [31:0] readData,
  output logic        hit,
  output logic [31:0] devData,
  output logic        devValid,
  input  logic        devReady,
  output logic        irq
);

  localparam int unsigned PW = CW - 1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          irq_q, irq_d;

  logic        data_sel, status_sel;
  logic        empty, full;
  logic        pop, push_req, push;
  logic        status_wr;
  logic [31:0] status_word;

  assign data_sel   = (address == DATA_ADDR);
  assign status_sel = (address == STATUS_ADDR);
  assign hit        = data_sel | status_sel;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign devValid = ~empty;
  assign devData  = mem_q[rd_ptr_q];
  assign irq      = irq_q;

  assign pop       = devValid & devReady;
  assign push_req  = memWrite & data_sel;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = push_req & (~full | pop);
  assign status_wr = memWrite & status_sel;

  always_comb begin
    status_word            = '0;
    status_word[0]         = empty;
    status_word[1]         = full;
    status_word[2]         = ovf_q;
    status_word[3]         = udf_q;
    status_word[4 +: CW]   = count_q;
  end

  // Reads reflect pre-edge state, even when a store hits the same address.
  always_comb begin
    readData = '0;
    if (data_sel) begin
      readData = empty ? 32'h0 : devData;
    end else if (status_sel) begin
      readData = status_word;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = writeData;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Set has priority over a software clear in the same cycle.
    ovf_d = ovf_q;
    if (status_wr && writeData[2]) ovf_d = 1'b0;
    if (push_req && !push)         ovf_d = 1'b1;

    udf_d = udf_q;
    if (status_wr && writeData[3])   udf_d = 1'b0;
    if (memRead && data_sel && empty) udf_d = 1'b1;

    irq_d = pop & ~push & (count_q == CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_device_buffer.sv
// Self-checking bench for mmio_device_buffer: a directed vector table, a few
// hand-written sequences and a randomized run, all compared against a
// queue-based reference model.
module tb_mmio_device_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] DA = 32'hFFFF8004;
  localparam logic [31:0] SA = 32'hFFFF8000;
  localparam logic [31:0] OA = 32'h00001000;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;
  logic        hit;
  logic [31:0] devData;
  logic        devValid;
  logic        devReady;
  logic        irq;

  mmio_device_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeData (writeData),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .readData  (readData),
    .hit       (hit),
    .devData   (devData),
    .devValid  (devValid),
    .devReady  (devReady),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] mq[$];
  logic        m_ovf, m_udf, m_irq;
  logic [31:0] last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[0]   = (mq.size() == 0);
    s[1]   = (mq.size() == DEPTH);
    s[2]   = m_ovf;
    s[3]   = m_udf;
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == DA) return (mq.size() == 0) ? 32'h0 : mq[0];
    if (a == SA) return m_status();
    return 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_irq = 1'b0;
  endtask

  // Apply inputs and compare everything observable before the next edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic mw, input logic mr, input logic rdy);
    address   = a;
    writeData = wd;
    memWrite  = mw;
    memRead   = mr;
    devReady  = rdy;
    #3;
    chk("hit", {31'b0, hit}, {31'b0, (a == DA) || (a == SA)});
    if (mr) chk("readData", readData, m_read(a));
    chk("devValid", {31'b0, devValid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) chk("devData", devData, mq[0]);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  // Clock edge, then advance the model from the inputs that were applied.
  task automatic commit();
    int  sz0;
    logic pop, push_req, acc;
    @(posedge clk);
    sz0      = mq.size();
    pop      = (sz0 > 0) && devReady;
    push_req = memWrite && (address == DA);
    acc      = push_req && ((sz0 < DEPTH) || pop);
    if (pop) last_pop = mq.pop_front();
    if (acc) mq.push_back(writeData);
    if (push_req && !acc) m_ovf = 1'b1;
    else if (memWrite && address == SA && writeData[2]) m_ovf = 1'b0;
    if (memRead && address == DA && sz0 == 0) m_udf = 1'b1;
    else if (memWrite && address == SA && writeData[3]) m_udf = 1'b0;
    m_irq = (sz0 == 1) && (mq.size() == 0);
    #1;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic mw, input logic mr, input logic rdy);
    drive(a, wd, mw, mr, rdy);
    commit();
  endtask

  task automatic idle_inputs();
    address   = OA;
    writeData = 32'h0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    devReady  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mw;
    logic        mr;
    logic        rdy;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int irq_seen;
    logic [31:0] first_pop;
    logic [31:0] a;

    tbl[0]  = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h01, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[1]  = '{DA, 32'hA1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[2]  = '{DA, 32'hA2, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[3]  = '{DA, 32'hA3, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[4]  = '{DA, 32'hA4, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[5]  = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h42, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[6]  = '{DA, 32'hA5, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[7]  = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h46, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[8]  = '{OA, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[9]  = '{OA, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b1, 32'hA2, 1'b1, 1'b0};
    tbl[10] = '{OA, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b1, 32'hA3, 1'b1, 1'b0};
    tbl[11] = '{OA, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b1, 32'hA4, 1'b1, 1'b0};
    tbl[12] = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h05, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[13] = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h05, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[14] = '{SA, 32'h4,  1'b1, 1'b1, 1'b0, 32'h05, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[15] = '{SA, 32'h0,  1'b0, 1'b1, 1'b0, 32'h01, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};

    reset = 1'b0;
    idle_inputs();
    model_reset();
    last_pop = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_devValid", {31'b0, devValid}, 32'h0);
    chk("rst_devData", devData, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;

    // Directed table: fill, overflow, drain, irq, flag clear.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].addr, tbl[i].wd, tbl[i].mw, tbl[i].mr, tbl[i].rdy);
      if (tbl[i].mr) chk($sformatf("tbl%0d_rd", i), readData, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_hit", i), {31'b0, hit}, {31'b0, tbl[i].exp_hit});
      chk($sformatf("tbl%0d_valid", i), {31'b0, devValid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), devData, tbl[i].exp_data);
      chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
      commit();
    end

    // Full FIFO with simultaneous pop accepts the store.
    for (int i = 1; i <= 4; i++) step(DA, 32'hB0 + i, 1'b1, 1'b0, 1'b0);
    step(DA, 32'hB0, 1'b1, 1'b0, 1'b1);
    drive(SA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("full_pop_status", readData, 32'h42);
    commit();
    drive(OA, 32'h0, 1'b0, 1'b0, 1'b1);
    first_pop = devData;
    commit();
    chk("full_pop_first", first_pop, 32'hB2);
    for (int i = 0; i < 3; i++) step(OA, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("full_pop_last", last_pop, 32'hB0);

    // Underflow on empty data read, then software clear.
    drive(DA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("udf_read", readData, 32'h0);
    commit();
    drive(SA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("udf_status", readData, 32'h09);
    commit();
    step(SA, 32'h8, 1'b1, 1'b0, 1'b0);
    drive(SA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("udf_cleared", readData, 32'h01);
    commit();

    // Pointer wrap with alternating push / pop.
    irq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(DA, 32'hC0 + i, 1'b1, 1'b0, 1'b1);
      if (irq) irq_seen++;
      commit();
      drive(SA, 32'h0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("wrap%0d_status", i), readData, 32'h10);
      if (irq) irq_seen++;
      commit();
      chk($sformatf("wrap%0d_order", i), last_pop, 32'hC0 + i);
    end
    drive(OA, 32'h0, 1'b0, 1'b0, 1'b0);
    if (irq) irq_seen++;
    commit();
    chk("wrap_irq_count", irq_seen, 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = DA;
        2:       a = SA;
        default: a = ($urandom_range(0, 1) == 0) ? OA : $urandom;
      endcase
      step(a, $urandom, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) == 0));
    end
    step(SA, 32'hC, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step(OA, 32'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with words queued.
    for (int i = 0; i < 3; i++) step(DA, 32'hD1 + i, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    chk("pre_rst_valid", {31'b0, devValid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, devValid}, 32'h0);
    chk("async_rst_data", devData, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    model_reset();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(SA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_status", readData, 32'h01);
    commit();
    drive(OA, 32'h5, 1'b1, 1'b1, 1'b0);
    chk("other_hit", {31'b0, hit}, 32'h0);
    chk("other_rd", readData, 32'h0);
    commit();
    drive(SA, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("other_unchanged", readData, 32'h01);
    commit();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
